// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// command encodings, CTRL bit positions, scan states and the leading-zero helper.
package seg7_pkg;

    localparam logic [1:0] REG_CMD   = 2'd0;
    localparam logic [1:0] REG_CTRL  = 2'd1;
    localparam logic [1:0] REG_VALUE = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_SRC      = 1;
    localparam int CTRL_BLANK_LZ = 2;
    localparam int CTRL_OVF      = 3;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_DRIVE = 2'd1,
        S_BLANK = 2'd2
    } scan_state_e;

    // True when digit idx is a leading zero: it and every higher nibble are 0.
    // The rightmost digit is never a leading zero so a value of 0 still shows.
    function automatic logic lz_blank(input logic [31:0] snap, input logic [2:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i >= int'(idx)) && (snap[4*i +: 4] != 4'd0)) begin
                all_zero = 1'b0;
            end
        end
        return all_zero && (idx != 3'd0);
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern, ordered {g,f,e,d,c,b,a}.
module seg7_hex_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Glyph lookup for 0-9 and A-F (lowercase b and d to keep them distinct).
    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0:    o_seg = 7'h40;
            4'h1:    o_seg = 7'h79;
            4'h2:    o_seg = 7'h24;
            4'h3:    o_seg = 7'h30;
            4'h4:    o_seg = 7'h19;
            4'h5:    o_seg = 7'h12;
            4'h6:    o_seg = 7'h02;
            4'h7:    o_seg = 7'h78;
            4'h8:    o_seg = 7'h00;
            4'h9:    o_seg = 7'h10;
            4'hA:    o_seg = 7'h08;
            4'hB:    o_seg = 7'h03;
            4'hC:    o_seg = 7'h46;
            4'hD:    o_seg = 7'h21;
            4'hE:    o_seg = 7'h06;
            4'hF:    o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Eight-digit multiplexed hex display with a free-running counter and a small
// register interface. The scan FSM snapshots its source once per frame so a
// frame never mixes old and new digits.
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int   REFRESH_DIV      = 10000,
    parameter logic BLANK_LZ_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic [7:0]  AN
);

    localparam int             PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    logic [31:0]   r_count;
    logic          r_run;
    logic          r_ovf;
    logic          r_src;
    logic          r_blank_lz;
    logic [31:0]   r_value;
    logic [31:0]   r_rdata;
    logic [31:0]   r_snap;
    scan_state_e   r_state;
    logic [2:0]    r_idx;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    logic [1:0]    w_sel;
    logic          w_cmd_wr;
    logic          w_start;
    logic          w_stop;
    logic          w_clear;
    logic [31:0]   w_rd_val;
    scan_state_e   w_state_nxt;
    logic [2:0]    w_idx_nxt;
    logic [PW-1:0] w_presc_nxt;
    logic [31:0]   w_snap_nxt;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg_dec;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_unused_addr;

    assign w_sel         = addr[3:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_cmd_wr      = we && (w_sel == REG_CMD);
    assign w_start       = w_cmd_wr && (wdata[1:0] == CMD_START);
    assign w_stop        = w_cmd_wr && (wdata[1:0] == CMD_STOP);
    assign w_clear       = w_cmd_wr && (wdata[1:0] == CMD_CLEAR);

    // Run flag and the writable CTRL/VALUE fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_src      <= 1'b0;
            r_blank_lz <= BLANK_LZ_DEFAULT;
            r_value    <= 32'd0;
        end else begin
            if (w_start) begin
                r_run <= 1'b1;
            end else if (w_stop) begin
                r_run <= 1'b0;
            end else begin
                r_run <= r_run;
            end
            if (we && (w_sel == REG_CTRL)) begin
                r_src      <= wdata[CTRL_SRC];
                r_blank_lz <= wdata[CTRL_BLANK_LZ];
            end else begin
                r_src      <= r_src;
                r_blank_lz <= r_blank_lz;
            end
            if (we && (w_sel == REG_VALUE)) begin
                r_value <= wdata;
            end else begin
                r_value <= r_value;
            end
        end
    end

    // Free-running counter with sticky wrap flag; a clear beats any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 32'd0;
            r_ovf   <= 1'b0;
        end else if (w_clear) begin
            r_count <= 32'd0;
            r_ovf   <= 1'b0;
        end else if (r_run) begin
            r_count <= r_count + 32'd1;
            r_ovf   <= r_ovf | (r_count == 32'hFFFF_FFFF);
        end else begin
            r_count <= r_count;
            r_ovf   <= r_ovf;
        end
    end

    // Read mux; sees register contents before any same-cycle write lands.
    always_comb begin
        w_rd_val = 32'd0;
        case (w_sel)
            REG_CMD:   w_rd_val = 32'd0;
            REG_CTRL: begin
                w_rd_val[CTRL_RUN]      = r_run;
                w_rd_val[CTRL_SRC]      = r_src;
                w_rd_val[CTRL_BLANK_LZ] = r_blank_lz;
                w_rd_val[CTRL_OVF]      = r_ovf;
            end
            REG_VALUE: w_rd_val = r_value;
            REG_COUNT: w_rd_val = r_count;
            default:   w_rd_val = 32'd0;
        endcase
    end

    // Read data register: captured on re, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
        end else if (re) begin
            r_rdata <= w_rd_val;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    // Scan FSM next state; outputs are derived from the next state so the
    // registered anode/segment drives line up with the state register.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc;
        w_snap_nxt  = r_snap;
        case (r_state)
            S_LOAD: begin
                w_snap_nxt  = r_src ? r_value : r_count;
                w_idx_nxt   = 3'd0;
                w_presc_nxt = {PW{1'b0}};
                w_state_nxt = S_DRIVE;
            end
            S_DRIVE: begin
                if (r_presc == PRESC_LAST) begin
                    w_presc_nxt = {PW{1'b0}};
                    w_state_nxt = S_BLANK;
                end else begin
                    w_presc_nxt = r_presc + PRESC_ONE;
                    w_state_nxt = S_DRIVE;
                end
            end
            S_BLANK: begin
                if (r_idx == 3'd7) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = S_DRIVE;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_idx_nxt   = 3'd0;
                w_presc_nxt = {PW{1'b0}};
            end
        endcase
    end

    assign w_nibble = w_snap_nxt[{w_idx_nxt, 2'b00} +: 4];

    seg7_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // Digit drive for the upcoming cycle: dark outside S_DRIVE or on a leading zero.
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 7'h7F;
        if ((w_state_nxt == S_DRIVE) && !(r_blank_lz && lz_blank(w_snap_nxt, w_idx_nxt))) begin
            w_an_nxt  = ~(8'h01 << w_idx_nxt);
            w_seg_nxt = w_seg_dec;
        end else begin
            w_an_nxt  = 8'hFF;
            w_seg_nxt = 7'h7F;
        end
    end

    // Scan state, frame snapshot and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_LOAD;
            r_idx   <= 3'd0;
            r_presc <= {PW{1'b0}};
            r_snap  <= 32'd0;
            r_an    <= 8'hFF;
            r_seg   <= 7'h7F;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_presc <= w_presc_nxt;
            r_snap  <= w_snap_nxt;
            r_an    <= w_an_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    assign rdata = r_rdata;
    assign AN    = r_an;
    assign {g, f, e, d, c, b, a} = r_seg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl with REFRESH_DIV=4 (41-cycle frames).
`timescale 1ns/1ps
module tb_seg7_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        a, b, c, d, e, f, g;
    logic [7:0]  AN;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rd_item_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        bit         chk_seg;
    } disp_item_t;

    rd_item_t   rd_q[$];
    disp_item_t disp_q[$];

    always #5 clk = ~clk;

    seg7_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ_DEFAULT(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
        .rdata(rdata), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .AN(AN)
    );

    // Bench-side cycle count since reset release (value = number of edges seen).
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endfunction

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Queue the 41 expected cycles of one frame, starting with its S_LOAD cycle.
    function automatic void push_frame(input logic [31:0] v, input bit blz);
        disp_item_t it;
        it.an = 8'hFF; it.seg = 7'h7F; it.chk_seg = 1'b0;
        disp_q.push_back(it);
        for (int k = 0; k < 8; k++) begin
            logic [31:0] hi;
            bit          blank;
            hi    = v >> (4 * k);
            blank = blz && (k != 0) && (hi == 32'd0);
            for (int p = 0; p < 4; p++) begin
                it.an      = blank ? 8'hFF : ~(8'h01 << k);
                it.seg     = hex_seg(v[4*k +: 4]);
                it.chk_seg = !blank;
                disp_q.push_back(it);
            end
            it.an = 8'hFF; it.seg = 7'h7F; it.chk_seg = 1'b0;
            disp_q.push_back(it);
        end
    endfunction

    // Read monitor: a read strobe seen at an edge is checked half a cycle later.
    always @(posedge clk) begin
        if (re && rst) begin
            @(negedge clk);
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%h required=queued_read", rdata);
            end else begin
                rd_item_t ri;
                ri = rd_q.pop_front();
                check(ri.name, rdata, ri.exp);
            end
        end
    end

    // Display monitor: one expected entry per cycle while a frame is queued.
    always @(negedge clk) begin
        if (disp_q.size() > 0) begin
            disp_item_t di;
            di = disp_q.pop_front();
            check($sformatf("an_cyc%0d", cyc), {24'd0, AN}, {24'd0, di.an});
            if (di.chk_seg) check($sformatf("seg_cyc%0d", cyc), {25'd0, g, f, e, d, c, b, a}, {25'd0, di.seg});
        end
    end

    task automatic bus_write(input logic [3:0] ad, input logic [31:0] dat);
        we = 1'b1; addr = ad; wdata = dat;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] ad, input logic [31:0] exp, input string nm);
        rd_item_t it;
        it.exp = exp; it.name = nm;
        rd_q.push_back(it);
        re = 1'b1; addr = ad;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic bus_rw(input logic [3:0] ad, input logic [31:0] dat, input logic [31:0] exp, input string nm);
        rd_item_t it;
        it.exp = exp; it.name = nm;
        rd_q.push_back(it);
        we = 1'b1; re = 1'b1; addr = ad; wdata = dat;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while ((cyc != target) && (n < 5000)) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("wait_cyc%0d", target), cyc, target);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (((disp_q.size() != 0) || (rd_q.size() != 0)) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check("queues_drained", disp_q.size() + rd_q.size(), 0);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", {24'd0, AN}, 32'h0000_00FF);
        check("rst_seg", {25'd0, g, f, e, d, c, b, a}, 32'h0000_007F);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b1;

        // Reset values and basic register access
        bus_read(4'h4, 32'h0000_0004, "ctrl_reset");
        bus_read(4'h8, 32'd0, "value_reset");
        bus_read(4'hC, 32'd0, "count_reset");
        bus_write(4'h8, 32'hDEAD_BEEF);
        bus_read(4'h9, 32'hDEAD_BEEF, "value_rw_addr_lsb_ignored");
        bus_read(4'h0, 32'd0, "cmd_reads_0");

        // Start (upper wdata bits ignored) and count 100 cycles
        bus_write(4'h0, 32'hFFFF_FFFD);
        repeat (100) @(negedge clk);
        bus_read(4'hC, 32'd100, "count_100");
        bus_read(4'h4, 32'h0000_0005, "ctrl_running");

        // Wrap from FFFF_FFFE: two increments give 0 and set OVF
        force dut.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_count;
        @(negedge clk);
        @(negedge clk);
        bus_read(4'hC, 32'd0, "count_wrap");
        bus_read(4'h4, 32'h0000_000D, "ctrl_ovf_set");

        // Clear while incrementing: clear wins, run unchanged, OVF cleared
        bus_write(4'h0, 32'h0000_0003);
        bus_read(4'hC, 32'd0, "count_clear_wins");
        bus_read(4'h4, 32'h0000_0005, "ctrl_after_clear");

        // Stop: the stop edge still increments once, then the count freezes
        bus_write(4'h0, 32'h0000_0002);
        bus_read(4'hC, 32'd3, "count_stopped");
        repeat (5) @(negedge clk);
        bus_read(4'hC, 32'd3, "count_frozen");
        bus_read(4'h4, 32'h0000_0004, "ctrl_stopped");

        // Read-only COUNT and reserved CTRL bits
        bus_write(4'hC, 32'h0000_1234);
        bus_read(4'hC, 32'd3, "count_ro");
        bus_write(4'h4, 32'hFFFF_FFFF);
        bus_read(4'h4, 32'h0000_0006, "ctrl_reserved");

        // Simultaneous write and read returns the old value
        bus_rw(4'h8, 32'h5555_AAAA, 32'hDEAD_BEEF, "rw_prewrite");
        bus_read(4'h8, 32'h5555_AAAA, "value_postwrite");
        wait_drain();

        // Display scan: fresh reset so frames line up with the cycle count
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_write(4'h4, 32'h0000_0006);
        bus_write(4'h8, 32'h0000_00A5);
        wait_cyc(41);
        push_frame(32'h0000_00A5, 1'b1);
        @(negedge clk);
        repeat (10) @(negedge clk);
        bus_write(4'h8, 32'h0000_003C);
        wait_cyc(82);
        push_frame(32'h0000_003C, 1'b1);
        @(negedge clk);
        bus_write(4'h8, 32'h0000_0000);
        wait_cyc(123);
        push_frame(32'h0000_0000, 1'b1);
        @(negedge clk);
        bus_write(4'h8, 32'h1234_5678);
        wait_drain();

        // Reset in the middle of digit 3 of the next frame
        wait_cyc(180);
        @(negedge clk);
        check("an_digit3", {24'd0, AN}, 32'h0000_00F7);
        check("seg_digit3", {25'd0, g, f, e, d, c, b, a}, {25'd0, hex_seg(4'h5)});
        #2;
        rst = 1'b0;
        #1;
        check("midrst_an", {24'd0, AN}, 32'h0000_00FF);
        check("midrst_seg", {25'd0, g, f, e, d, c, b, a}, 32'h0000_007F);
        check("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus_read(4'h4, 32'h0000_0004, "ctrl_after_midrst");
        bus_read(4'h8, 32'd0, "value_after_midrst");
        bus_read(4'hC, 32'd0, "count_after_midrst");
        wait_cyc(41);
        push_frame(32'h0000_0000, 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
